pwm_chain_gen: RTL and testbench

Parametrised successor to the single-chain PWM generator. It contains one timebase counter with three counting modes, N compare channels with shadow registers, and per-channel complementary outputs with dead-time insertion. Configuration arrives on a simple register-write port (address/data/valid), which the AXI-lite slave wrapper drives. The block sits between the top-level timebase (tick source) and the gate-drive pins.

---
 rtl/pwm_chain_pkg.sv | 29 ++
 rtl/pwm_deadtime_pair.sv | 67 ++++++
 rtl/pwm_chain_gen.sv | 159 +++++++++++++++
 tb/tb_pwm_chain_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_chain_pkg.sv
// Shared types and register map for the multi-channel PWM generator.
package pwm_chain_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_TRIANGLE = 2'd2
    } pwm_mode_e;

    localparam logic [7:0] CTRL_ADDR     = 8'h00;
    localparam logic [7:0] PERIOD_ADDR   = 8'h04;
    localparam logic [7:0] DEADTIME_ADDR = 8'h08;
    localparam logic [7:0] COMPARE_BASE  = 8'h10;

    localparam int CTRL_RUN_BIT         = 0;
    localparam int CTRL_MODE_LSB        = 1;
    localparam int CTRL_MODE_MSB        = 2;
    localparam int CTRL_FAULT_CLEAR_BIT = 4;

    // Encoding 3 has no mode of its own and behaves as up-sawtooth.
    function automatic pwm_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_DOWN;
            2'd2:    return MODE_TRIANGLE;
            default: return MODE_UP;
        endcase
    endfunction

endpackage

// File: rtl/pwm_deadtime_pair.sv
// Complementary high/low driver with dead-time insertion for one PWM channel.
// state    | meaning
// ST_WAIT  | both sides off, dead-time counter running down to terminal count
// ST_DRIVE | one side on, matching the current raw level
module pwm_deadtime_pair #(
    parameter int DEADTIME_WIDTH = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      raw,
    input  logic [DEADTIME_WIDTH-1:0] deadtime,
    output logic                      high,
    output logic                      low
);

    typedef enum logic {ST_WAIT, ST_DRIVE} dt_state_e;

    dt_state_e                 state, state_next;
    logic [DEADTIME_WIDTH-1:0] cnt, cnt_next;
    logic                      raw_q;
    logic                      high_next, low_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT;
            cnt   <= '0;
            raw_q <= 1'b0;
            high  <= 1'b0;
            low   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            raw_q <= raw;
            high  <= high_next;
            low   <= low_next;
        end
    end

    // The edge cycle itself counts as the first dead clock, hence deadtime-1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        high_next  = high;
        low_next   = low;
        if (raw != raw_q) begin
            if (deadtime == '0) begin
                state_next = ST_DRIVE;
                high_next  = raw;
                low_next   = !raw;
            end else begin
                state_next = ST_WAIT;
                high_next  = 1'b0;
                low_next   = 1'b0;
                cnt_next   = deadtime - 1'b1;
            end
        end else if (state == ST_WAIT) begin
            if (cnt == '0 || deadtime == '0) begin
                state_next = ST_DRIVE;
                high_next  = raw;
                low_next   = !raw;
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_chain_gen.sv
// Timebase counter with up/down/triangle modes, shadowed compare channels and
// dead-time protected complementary outputs, configured through a write port.
module pwm_chain_gen
    import pwm_chain_pkg::*;
#(
    parameter int N_CHANNELS     = 3,
    parameter int COUNTER_WIDTH  = 16,
    parameter int DEADTIME_WIDTH = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    timebase_tick,
    input  logic                    cfg_valid,
    input  logic [7:0]              cfg_addr,
    input  logic [31:0]             cfg_data,
    input  logic                    fault,
    output logic [2*N_CHANNELS-1:0] pwm_out,
    output logic                    period_sync,
    output logic                    fault_latched
);

    logic                      run;
    pwm_mode_e                 mode;
    logic [DEADTIME_WIDTH-1:0] deadtime;
    logic [COUNTER_WIDTH-1:0]  period_shadow, period_active;
    logic [COUNTER_WIDTH-1:0]  cmp_shadow [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0]  cmp_active [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0]  counter, counter_next;
    logic                      dir_down, dir_down_next;
    logic                      boundary;
    logic [N_CHANNELS-1:0]     raw, pair_high, pair_low;
    logic                      wr_ctrl, fault_clear;
    pwm_mode_e                 mode_wr;
    logic                      unused_cfg;

    assign wr_ctrl     = cfg_valid && (cfg_addr == CTRL_ADDR);
    assign fault_clear = wr_ctrl && cfg_data[CTRL_FAULT_CLEAR_BIT];
    assign mode_wr     = decode_mode(cfg_data[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    assign unused_cfg  = ^cfg_data;

    always_comb begin
        boundary      = 1'b0;
        counter_next  = counter;
        dir_down_next = dir_down;
        if (run && timebase_tick) begin
            if (period_active == '0) begin
                boundary     = 1'b1;
                counter_next = '0;
            end else begin
                case (mode)
                    MODE_DOWN: begin
                        if (counter == '0) begin
                            boundary     = 1'b1;
                            counter_next = period_shadow;
                        end else begin
                            counter_next = counter - 1'b1;
                        end
                    end
                    MODE_TRIANGLE: begin
                        if (!dir_down) begin
                            if (counter >= period_active) begin
                                dir_down_next = 1'b1;
                                counter_next  = period_active - 1'b1;
                            end else begin
                                counter_next = counter + 1'b1;
                            end
                        end else if (counter == '0) begin
                            boundary      = 1'b1;
                            dir_down_next = 1'b0;
                            counter_next  = COUNTER_WIDTH'(1);
                        end else begin
                            counter_next = counter - 1'b1;
                        end
                    end
                    default: begin
                        if (counter >= period_active) begin
                            boundary     = 1'b1;
                            counter_next = '0;
                        end else begin
                            counter_next = counter + 1'b1;
                        end
                    end
                endcase
            end
        end
        if (!run) begin
            counter_next  = '0;
            dir_down_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run           <= 1'b0;
            mode          <= MODE_UP;
            deadtime      <= '0;
            period_shadow <= '0;
            period_active <= '0;
            counter       <= '0;
            dir_down      <= 1'b0;
            period_sync   <= 1'b0;
            fault_latched <= 1'b0;
            raw           <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                cmp_shadow[i] <= '0;
                cmp_active[i] <= '0;
            end
        end else begin
            counter     <= counter_next;
            dir_down    <= dir_down_next;
            period_sync <= boundary;

            // Active values read the shadows before this cycle's write lands.
            if (!run || boundary) begin
                period_active <= period_shadow;
                for (int i = 0; i < N_CHANNELS; i++) cmp_active[i] <= cmp_shadow[i];
            end

            if (wr_ctrl) begin
                run  <= cfg_data[CTRL_RUN_BIT];
                mode <= mode_wr;
                if (mode_wr != mode) dir_down <= 1'b0;
            end
            if (cfg_valid && cfg_addr == PERIOD_ADDR) period_shadow <= cfg_data[COUNTER_WIDTH-1:0];
            if (cfg_valid && cfg_addr == DEADTIME_ADDR) deadtime <= cfg_data[DEADTIME_WIDTH-1:0];
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (cfg_valid && cfg_addr == COMPARE_BASE + 8'(4 * i))
                    cmp_shadow[i] <= cfg_data[COUNTER_WIDTH-1:0];
            end

            if (fault) fault_latched <= 1'b1;
            else if (fault_clear) fault_latched <= 1'b0;

            for (int i = 0; i < N_CHANNELS; i++) raw[i] <= (counter < cmp_active[i]);
        end
    end

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
        pwm_deadtime_pair #(.DEADTIME_WIDTH(DEADTIME_WIDTH)) u_pair (
            .clock    (clock),
            .reset    (reset),
            .raw      (raw[g]),
            .deadtime (deadtime),
            .high     (pair_high[g]),
            .low      (pair_low[g])
        );
    end

    always_comb begin
        pwm_out = '0;
        if (run && !fault_latched) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                pwm_out[2*i]   = pair_high[i];
                pwm_out[2*i+1] = pair_low[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_chain_gen.sv
// Directed bench for pwm_chain_gen: duty/period counts over whole periods,
// dead time, shadow timing, fault latch and async reset.
module tb_pwm_chain_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        timebase_tick;
    logic        cfg_valid;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        fault;
    logic [5:0]  pwm_out;
    logic        period_sync;
    logic        fault_latched;

    int n_vec  = 0;
    int n_miss = 0;

    int bit_cnt [6];
    int sync_cnt, overlap_cnt, comp_err_cnt, nz_cnt;

    pwm_chain_gen #(
        .N_CHANNELS     (3),
        .COUNTER_WIDTH  (16),
        .DEADTIME_WIDTH (10)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .timebase_tick (timebase_tick),
        .cfg_valid     (cfg_valid),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .fault         (fault),
        .pwm_out       (pwm_out),
        .period_sync   (period_sync),
        .fault_latched (fault_latched)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clock);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    // Samples n consecutive negedges starting at the current one.
    task automatic measure(input int n);
        for (int b = 0; b < 6; b++) bit_cnt[b] = 0;
        sync_cnt = 0; overlap_cnt = 0; comp_err_cnt = 0; nz_cnt = 0;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 6; b++) bit_cnt[b] += int'(pwm_out[b]);
            sync_cnt += int'(period_sync);
            for (int c = 0; c < 3; c++) if (pwm_out[2*c] && pwm_out[2*c+1]) overlap_cnt++;
            if (pwm_out != 6'd0) nz_cnt++;
            if (pwm_out[0] == pwm_out[1]) comp_err_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic wait_sync();
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!period_sync && k < 64);
        if (!period_sync) check("sync_timeout", 0, 1);
    endtask

    task automatic sync_gap(input string tag, input int exp);
        int g = 0;
        wait_sync();
        do begin
            @(negedge clock);
            g++;
        end while (!period_sync && g < 64);
        check(tag, g, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] p0;
        int changed, syn;

        reset = 1'b1; timebase_tick = 1'b1; cfg_valid = 1'b0;
        cfg_addr = '0; cfg_data = '0; fault = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_sync", int'(period_sync), 0);
        check("rst_fault", int'(fault_latched), 0);
        reset = 1'b0;

        // Up-sawtooth, period 10 clocks; ch0 4/10, ch1 compare 0, ch2 compare > period.
        wr(8'h04, 32'd9);
        wr(8'h10, 32'd4);
        wr(8'h18, 32'hFFFF_0014);
        wr(8'h08, 32'd0);
        wr(8'h00, 32'h1);
        repeat (30) @(negedge clock);
        measure(40);
        check("up_hi0", bit_cnt[0], 16);
        check("up_lo0", bit_cnt[1], 24);
        check("up_complement", comp_err_cnt, 0);
        check("up_hi1_cmp0", bit_cnt[2], 0);
        check("up_lo1_cmp0", bit_cnt[3], 40);
        check("up_hi2_cmp_gt_per", bit_cnt[4], 40);
        check("up_lo2_cmp_gt_per", bit_cnt[5], 0);
        check("up_sync", sync_cnt, 4);
        check("up_overlap", overlap_cnt, 0);
        sync_gap("up_sync_gap", 10);

        // Tick held low freezes everything once the pipeline drains.
        timebase_tick = 1'b0;
        repeat (3) @(negedge clock);
        p0 = pwm_out; changed = 0; syn = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (pwm_out != p0) changed++;
            syn += int'(period_sync);
        end
        check("hold_pwm", changed, 0);
        check("hold_sync", syn, 0);
        timebase_tick = 1'b1;

        // Triangle, period 8: counter 0,1..8,7..1 -> 16 clocks; below 3: 0,1,2,2,1.
        wr(8'h00, 32'h0);
        wr(8'h04, 32'd8);
        wr(8'h14, 32'd3);
        wr(8'h00, 32'h5);
        repeat (20) @(negedge clock);
        measure(48);
        check("tri_hi1", bit_cnt[2], 15);
        check("tri_hi0", bit_cnt[0], 21);
        check("tri_hi2", bit_cnt[4], 48);
        check("tri_sync", sync_cnt, 3);
        check("tri_overlap", overlap_cnt, 0);
        sync_gap("tri_sync_gap", 16);

        // Dead time 3 in up mode, period 10.
        wr(8'h00, 32'h1);
        wr(8'h04, 32'd9);
        wr(8'h10, 32'd4);
        wr(8'h08, 32'd3);
        repeat (30) @(negedge clock);
        measure(40);
        check("dt_hi0", bit_cnt[0], 4);
        check("dt_lo0", bit_cnt[1], 12);
        check("dt_hi1_3clk_pulse", bit_cnt[2], 0);
        check("dt_lo1", bit_cnt[3], 16);
        check("dt_hi2_const", bit_cnt[4], 40);
        check("dt_overlap", overlap_cnt, 0);
        wr(8'h10, 32'd2);
        repeat (30) @(negedge clock);
        measure(40);
        check("dt_short_hi0", bit_cnt[0], 0);
        check("dt_short_lo0", bit_cnt[1], 20);
        check("dt_short_overlap", overlap_cnt, 0);

        // Shadow timing: mid-period write, then write coincident with the wrap.
        wr(8'h08, 32'd0);
        wr(8'h10, 32'd4);
        repeat (25) @(negedge clock);
        wait_sync();
        wr(8'h10, 32'd2);
        measure(10);
        check("sh_mid_old", bit_cnt[0], 4);
        measure(10);
        check("sh_mid_new", bit_cnt[0], 2);
        wait_sync();
        repeat (9) @(negedge clock);
        cfg_valid = 1'b1; cfg_addr = 8'h10; cfg_data = 32'd6;
        @(negedge clock);
        cfg_valid = 1'b0;
        repeat (2) @(negedge clock);
        measure(10);
        check("sh_coin_old", bit_cnt[0], 2);
        measure(10);
        check("sh_coin_new", bit_cnt[0], 6);

        // Fault latch and clear.
        fault = 1'b1;
        @(negedge clock);
        fault = 1'b0;
        check("flt_set", int'(fault_latched), 1);
        check("flt_pwm", int'(pwm_out), 0);
        measure(20);
        check("flt_nz", nz_cnt, 0);
        check("flt_sync_runs", sync_cnt, 2);
        check("flt_sticky", int'(fault_latched), 1);
        fault = 1'b1;
        wr(8'h00, 32'h11);
        fault = 1'b0;
        @(negedge clock);
        check("flt_clear_ignored", int'(fault_latched), 1);
        wr(8'h00, 32'h11);
        check("flt_cleared", int'(fault_latched), 0);
        measure(20);
        check("flt_restored_hi0", bit_cnt[0], 12);
        check("flt_restored_lo0", bit_cnt[1], 8);

        // Down-sawtooth, period 10, compare 6.
        wr(8'h00, 32'h3);
        repeat (25) @(negedge clock);
        measure(20);
        check("dn_hi0", bit_cnt[0], 12);
        check("dn_sync", sync_cnt, 2);
        check("dn_overlap", overlap_cnt, 0);
        sync_gap("dn_sync_gap", 10);

        // Async reset between clock edges.
        check("pre_rst_nz", int'(pwm_out != 6'd0), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_pwm", int'(pwm_out), 0);
        check("arst_sync", int'(period_sync), 0);
        check("arst_fault", int'(fault_latched), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        // Shadows cleared: period 0 means every tick is a boundary, compares 0.
        wr(8'h00, 32'h1);
        repeat (4) @(negedge clock);
        measure(10);
        check("z_sync", sync_cnt, 10);
        check("z_hi0", bit_cnt[0], 0);
        check("z_lo0", bit_cnt[1], 10);
        check("z_hi2", bit_cnt[4], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
